// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit adder, one nibble per clock through a 4-bit carry-select slice.
// Ports: clk, rst (sync, active-high); in_valid/in_ready + a, b, cin (input handshake);
//        out_valid/out_ready + sum, cout (output handshake); ovf only with SERIAL_ADD_OVF_EN.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_d;
  logic [IW-1:0]    idx_q;
  logic             carry_q;
  logic             cout_q;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q;
`endif

  logic [3:0] a_nib;
  logic [3:0] b_nib;
  logic [4:0] res0;
  logic [4:0] res1;
  logic [4:0] res;
  logic       last;

  assign a_nib = a_q[4*idx_q +: 4];
  assign b_nib = b_q[4*idx_q +: 4];

  // Both carry outcomes are formed up front; carry_q only picks one.
  assign res0 = {1'b0, a_nib} + {1'b0, b_nib};
  assign res1 = {1'b0, a_nib} + {1'b0, b_nib} + 5'd1;
  assign res  = carry_q ? res1 : res0;
  assign last = (idx_q == LAST);

  always_comb begin
    sum_d = sum_q;
    sum_d[4*idx_q +: 4] = res[3:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx_q   <= '0;
            sum_q   <= '0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q   <= sum_d;
          carry_q <= res[4];
          if (last) begin
            cout_q  <= res[4];
`ifdef SERIAL_ADD_OVF_EN
            // res[3] is the new sum MSB in the final nibble.
            ovf_q   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                       (res[3] != a_q[WIDTH-1]);
`endif
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed and random checks of nibble_serial_adder
// against an arithmetic reference ({cout,sum} = a + b + cin).
module tb_nibble_serial_adder;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
`ifdef SERIAL_ADD_OVF_EN
    .ovf       (ovf),
`endif
    .cout      (cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation, wait for the result, hold out_ready low for
  // bp cycles (offering a distractor operand), then retire it.
  task automatic do_op(input string tag, input logic [W-1:0] ta,
                       input logic [W-1:0] tb, input logic tc,
                       input int bp);
    logic [W:0] ref_s;
    logic       ref_o;
    int         lat;
    ref_s = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
    ref_o = (ta[W-1] == tb[W-1]) && (ref_s[W-1] != ta[W-1]);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    in_valid = 1'b1;
    a = ta;
    b = tb;
    cin = tc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, NIB);
    chk({tag, "_sum"}, sum, ref_s[W-1:0]);
    chk({tag, "_cout"}, cout, ref_s[W]);
`ifdef SERIAL_ADD_OVF_EN
    chk({tag, "_ovf"}, ovf, ref_o);
`endif
    if (bp > 0) begin
      in_valid = 1'b1;
      a = 16'h0F0F;
      b = 16'h0F0F;
      repeat (bp) begin
        @(posedge clk);
        #1;
      end
      in_valid = 1'b0;
      chk({tag, "_bp_valid"}, out_valid, 1'b1);
      chk({tag, "_bp_inrdy"}, in_ready, 1'b0);
      chk({tag, "_bp_sum"}, sum, ref_s[W-1:0]);
      chk({tag, "_bp_cout"}, cout, ref_s[W]);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_retire_valid"}, out_valid, 1'b0);
    chk({tag, "_retire_inrdy"}, in_ready, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b0;
    a = 16'hAAAA;
    b = 16'h5555;
    cin = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_sum", sum, 16'h0000);
    chk("rst_cout", cout, 1'b0);
`ifdef SERIAL_ADD_OVF_EN
    chk("rst_ovf", ovf, 1'b0);
`endif

    do_op("basic", 16'h1234, 16'h4321, 1'b0, 0);
    do_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 0);
    do_op("ovf_pos", 16'h7FFF, 16'h0000, 1'b1, 0);
    do_op("ovf_neg", 16'h8000, 16'h8000, 1'b0, 0);
    do_op("backpr", 16'hABCD, 16'h1111, 1'b1, 3);
    do_op("fresh", 16'h0100, 16'h0200, 1'b0, 0);

    // Abort mid-RUN: reset sampled while idx==2.
    in_valid = 1'b1;
    a = 16'hFFFF;
    b = 16'hFFFF;
    cin = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_in_ready", in_ready, 1'b1);
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_sum", sum, 16'h0000);
    repeat (NIB + 1) @(posedge clk);
    #1;
    chk("abort_no_valid", out_valid, 1'b0);
    do_op("post_abort", 16'h0001, 16'h0002, 1'b1, 0);

    for (int i = 0; i < 24; i++) begin
      do_op("rand", W'($urandom), W'($urandom), 1'($urandom),
            int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
